// File: rtl/core_pkg.sv
// Shared core definitions: hazard scheduler state encoding and the NOP used
// by the flush/bubble consumers in IF/ID and ID/EX.
package core_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_MD_WAIT = 2'd2
   } hs_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int FLUSH_CNT_W = 2;

endpackage

// File: rtl/hazard_sched_if.sv
// Hazard scheduler bundle: ID/EX hazard inputs and pipeline control outputs.
// master = pipeline side, slave = scheduler side.
interface hazard_sched_if;

   logic [4:0] rs1id;
   logic [4:0] rs2id;
   logic       usesrs1id;
   logic       usesrs2id;
   logic [4:0] destex;
   logic       memreadex;
   logic       redirectex;
   logic       mdstartex;
   logic       mddone;

   logic       pcwrite;
   logic       ifidwrite;
   logic       idexbubble;
   logic       ifidflush;
   logic       idexflush;
   logic       exhold;
   logic       mderr;
   logic [1:0] state;

   modport master (
      output rs1id, rs2id, usesrs1id, usesrs2id, destex, memreadex,
             redirectex, mdstartex, mddone,
      input  pcwrite, ifidwrite, idexbubble, ifidflush, idexflush,
             exhold, mderr, state
   );

   modport slave (
      input  rs1id, rs2id, usesrs1id, usesrs2id, destex, memreadex,
             redirectex, mdstartex, mddone,
      output pcwrite, ifidwrite, idexbubble, ifidflush, idexflush,
             exhold, mderr, state
   );

endinterface

// File: rtl/lu_detect.sv
// Combinational load-use comparator: EX load whose rd feeds an ID source.
// x0 is never a hazard since it cannot be written.
module lu_detect (
   input  logic [4:0] rs1id,
   input  logic [4:0] rs2id,
   input  logic       usesrs1id,
   input  logic       usesrs2id,
   input  logic [4:0] destex,
   input  logic       memreadex,
   output logic       lu
);

   logic hit1;
   logic hit2;

   assign hit1 = usesrs1id && (rs1id == destex);
   assign hit2 = usesrs2id && (rs2id == destex);
   assign lu   = memreadex && (destex != 5'd0) && (hit1 || hit2);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use stalls, redirect flushes and mul/div
// EX occupancy. HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter.
module hazard_sched
   import core_pkg::*;
#(
   parameter int MD_MAX    = 64,
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   hazard_sched_if.slave        hif
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]     stallcnt
`endif
);

   localparam int MDC_W = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;
   localparam logic [MDC_W-1:0]       MD_LAST    = MDC_W'(MD_MAX - 1);
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYC - 1);

   logic [1:0]             state_q, state_d;
   logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
   logic [MDC_W-1:0]       mdcnt_q, mdcnt_d;
   logic                   mderr_q, mderr_d;

   logic lu;
   logic pcwrite, ifidwrite, idexbubble, ifidflush, idexflush, exhold;

   lu_detect u_lu (
      .rs1id     (hif.rs1id),
      .rs2id     (hif.rs2id),
      .usesrs1id (hif.usesrs1id),
      .usesrs2id (hif.usesrs2id),
      .destex    (hif.destex),
      .memreadex (hif.memreadex),
      .lu        (lu)
   );

   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      mdcnt_d    = mdcnt_q;
      mderr_d    = mderr_q;
      pcwrite    = 1'b1;
      ifidwrite  = 1'b1;
      idexbubble = 1'b0;
      ifidflush  = 1'b0;
      idexflush  = 1'b0;
      exhold     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (hif.redirectex) begin
               ifidflush = 1'b1;
               idexflush = 1'b1;
               if (FLUSH_CYC > 1) begin
                  state_d = ST_FLUSH;
                  fcnt_d  = FLUSH_INIT;
               end
            end else if (hif.mdstartex) begin
               // MD op enters EX this cycle; the freeze starts next cycle
               state_d = ST_MD_WAIT;
               mdcnt_d = '0;
            end else if (lu) begin
               pcwrite    = 1'b0;
               ifidwrite  = 1'b0;
               idexbubble = 1'b1;
            end
         end

         ST_FLUSH: begin
            ifidflush = 1'b1;
            idexflush = 1'b1;
            if (fcnt_q <= FLUSH_CNT_W'(1)) begin
               fcnt_d  = '0;
               state_d = ST_RUN;
            end else begin
               fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
            end
         end

         ST_MD_WAIT: begin
            if (hif.mddone) begin
               state_d = ST_RUN;
               mdcnt_d = '0;
            end else if (mdcnt_q == MD_LAST) begin
               // timeout releases the pipe exactly like a completion
               state_d = ST_RUN;
               mdcnt_d = '0;
               mderr_d = 1'b1;
            end else begin
               pcwrite   = 1'b0;
               ifidwrite = 1'b0;
               exhold    = 1'b1;
               mdcnt_d   = mdcnt_q + MDC_W'(1);
            end
         end

         default: begin
            state_d = ST_RUN;
            fcnt_d  = '0;
            mdcnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         mdcnt_q <= '0;
         mderr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         mdcnt_q <= mdcnt_d;
         mderr_q <= mderr_d;
      end
   end

   assign hif.pcwrite    = pcwrite;
   assign hif.ifidwrite  = ifidwrite;
   assign hif.idexbubble = idexbubble;
   assign hif.ifidflush  = ifidflush;
   assign hif.idexflush  = idexflush;
   assign hif.exhold     = exhold;
   assign hif.mderr      = mderr_q;
   assign hif.state      = state_q;

`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stallcnt_q, stallcnt_d;

   always_comb begin
      stallcnt_d = stallcnt_q;
      if (!pcwrite && (stallcnt_q != {CNT_W{1'b1}}))
         stallcnt_d = stallcnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) stallcnt_q <= '0;
      else       stallcnt_q <= stallcnt_d;
   end

   assign stallcnt = stallcnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched (FLUSH_CYC=2, MD_MAX=8); optional
// stall counter checked when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_sched;

   logic CLK;
   logic RSTn;
   int   n_chk = 0;
   int   n_err = 0;

   hazard_sched_if hif ();

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stallcnt;
`endif

   hazard_sched #(.MD_MAX(8), .FLUSH_CYC(2), .CNT_W(16)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .hif  (hif)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stallcnt (stallcnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      hif.rs1id = 5'd0; hif.rs2id = 5'd0; hif.usesrs1id = 1'b0; hif.usesrs2id = 1'b0;
      hif.destex = 5'd0; hif.memreadex = 1'b0; hif.redirectex = 1'b0;
      hif.mdstartex = 1'b0; hif.mddone = 1'b0;
   endtask

   // next cycle, inputs change 1 time unit after the edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_lu(input logic [4:0] rd);
      hif.memreadex = 1'b1; hif.destex = rd; hif.rs1id = rd; hif.usesrs1id = 1'b1;
   endtask

   task automatic chk_stall(input string tag, input logic exp);
      chk({tag, "_pc"},   {31'd0, hif.pcwrite},   {31'd0, ~exp});
      chk({tag, "_ifid"}, {31'd0, hif.ifidwrite}, {31'd0, ~exp});
      chk({tag, "_hold"}, {31'd0, hif.exhold},    {31'd0, exp});
   endtask

   initial begin
      RSTn = 1'b0;
      idle();
      #12;
      chk("rst_state", {30'd0, hif.state}, 32'd0);
      chk("rst_pc",    {31'd0, hif.pcwrite}, 32'd1);
      chk("rst_ifid",  {31'd0, hif.ifidwrite}, 32'd1);
      chk("rst_ctl",   {28'd0, hif.idexbubble, hif.ifidflush, hif.idexflush, hif.exhold}, 32'd0);
      chk("rst_err",   {31'd0, hif.mderr}, 32'd0);
      RSTn = 1'b1;
      cyc();

      // load-use on rs1
      set_lu(5'd5);
      #3;
      chk("lu1_pc",     {31'd0, hif.pcwrite}, 32'd0);
      chk("lu1_ifid",   {31'd0, hif.ifidwrite}, 32'd0);
      chk("lu1_bubble", {31'd0, hif.idexbubble}, 32'd1);
      cyc(); idle(); #3;
      chk("lu1_after_pc", {31'd0, hif.pcwrite}, 32'd1);
      chk("lu1_after_bb", {31'd0, hif.idexbubble}, 32'd0);
      // destex = x0 never stalls
      cyc(); set_lu(5'd0); #3;
      chk("lu_x0_bb", {31'd0, hif.idexbubble}, 32'd0);
      chk("lu_x0_pc", {31'd0, hif.pcwrite}, 32'd1);
      // rs2 match counts only when rs2 is used
      cyc(); idle();
      hif.memreadex = 1'b1; hif.destex = 5'd7; hif.rs2id = 5'd7; #3;
      chk("lu_rs2_unused", {31'd0, hif.idexbubble}, 32'd0);
      cyc(); hif.usesrs2id = 1'b1; #3;
      chk("lu_rs2_bb", {31'd0, hif.idexbubble}, 32'd1);
      chk("lu_rs2_pc", {31'd0, hif.pcwrite}, 32'd0);

      // redirect, two flush cycles, lu ignored in the second
      cyc(); idle(); hif.redirectex = 1'b1; #3;
      chk("rd0_flush", {30'd0, hif.ifidflush, hif.idexflush}, 32'd3);
      chk("rd0_pc",    {31'd0, hif.pcwrite}, 32'd1);
      cyc(); idle(); set_lu(5'd3); #3;
      chk("rd1_state", {30'd0, hif.state}, 32'd1);
      chk("rd1_flush", {30'd0, hif.ifidflush, hif.idexflush}, 32'd3);
      chk("rd1_bb",    {31'd0, hif.idexbubble}, 32'd0);
      chk("rd1_pc",    {31'd0, hif.pcwrite}, 32'd1);
      cyc(); idle(); #3;
      chk("rd2_state", {30'd0, hif.state}, 32'd0);
      chk("rd2_flush", {30'd0, hif.ifidflush, hif.idexflush}, 32'd0);

      // mul/div: 5 frozen cycles, release on mddone
      cyc(); hif.mdstartex = 1'b1; #3;
      chk("md0_state", {30'd0, hif.state}, 32'd0);
      chk_stall("md0", 1'b0);
      cyc(); idle();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin hif.redirectex = 1'b1; set_lu(5'd4); end
         #3;
         chk("mdw_state", {30'd0, hif.state}, 32'd2);
         chk_stall("mdw", 1'b1);
         chk("mdw_flush", {31'd0, hif.ifidflush}, 32'd0);
         cyc(); idle();
      end
      hif.mddone = 1'b1; #3;
      chk_stall("mddone", 1'b0);
      cyc(); idle(); #3;
      chk("md_end_state", {30'd0, hif.state}, 32'd0);
      chk("md_end_err",   {31'd0, hif.mderr}, 32'd0);

      // mddone on the timeout cycle wins
      cyc(); hif.mdstartex = 1'b1; cyc(); idle();
      for (int i = 0; i < 7; i++) cyc();
      hif.mddone = 1'b1; #3;
      chk_stall("lastdone", 1'b0);
      cyc(); idle(); #3;
      chk("lastdone_state", {30'd0, hif.state}, 32'd0);
      chk("lastdone_err",   {31'd0, hif.mderr}, 32'd0);

      // timeout: 8 cycles in MD_WAIT, sticky mderr
      cyc(); hif.mdstartex = 1'b1; cyc(); idle();
      for (int i = 0; i < 7; i++) begin
         #3;
         chk_stall("to_wait", 1'b1);
         cyc();
      end
      #3;
      chk("to_last_state", {30'd0, hif.state}, 32'd2);
      chk_stall("to_last", 1'b0);
      chk("to_last_err", {31'd0, hif.mderr}, 32'd0);
      cyc(); #3;
      chk("to_state", {30'd0, hif.state}, 32'd0);
      chk("to_err",   {31'd0, hif.mderr}, 32'd1);
      cyc(); cyc(); #3;
      chk("to_err_sticky", {31'd0, hif.mderr}, 32'd1);

      // priority: redirect beats mdstart and lu
      cyc(); hif.redirectex = 1'b1; hif.mdstartex = 1'b1; set_lu(5'd9); #3;
      chk("pri_flush", {30'd0, hif.ifidflush, hif.idexflush}, 32'd3);
      chk("pri_bb",    {31'd0, hif.idexbubble}, 32'd0);
      chk("pri_pc",    {31'd0, hif.pcwrite}, 32'd1);
      cyc(); idle(); #3;
      chk("pri_state1", {30'd0, hif.state}, 32'd1);
      cyc(); #3;
      chk("pri_state2", {30'd0, hif.state}, 32'd0);
      chk("pri_nohold", {31'd0, hif.exhold}, 32'd0);

      // async reset in the third MD_WAIT cycle
      cyc(); hif.mdstartex = 1'b1; cyc(); idle(); cyc(); cyc(); #3;
      chk("rmd_hold", {31'd0, hif.exhold}, 32'd1);
`ifdef HAZARD_STALL_CNT_EN
      chk("scnt_pre", {16'd0, stallcnt}, 32'd23);
`endif
      RSTn = 1'b0; #1;
      chk("rmd_state", {30'd0, hif.state}, 32'd0);
      chk("rmd_pc",    {31'd0, hif.pcwrite}, 32'd1);
      chk("rmd_hold0", {31'd0, hif.exhold}, 32'd0);
      chk("rmd_err",   {31'd0, hif.mderr}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
      chk("scnt_rst", {16'd0, stallcnt}, 32'd0);
`endif
      RSTn = 1'b1;
      cyc(); cyc(); #3;
      chk("rmd_after", {30'd0, hif.state}, 32'd0);
      chk("rmd_after_pc", {31'd0, hif.pcwrite}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
